// File: rtl/srt4_iter_ctrl.sv
// rtl/srt4_iter_ctrl.sv - sequential radix-4 SRT unsigned divider, drives an external digit-selection table
// Define SRT4_REM_EN to add the registered remainder output.
module srt4_iter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [5:0]       qs_rem,
  output logic [3:0]       qs_d,
  input  logic [1:0]       qs_q,
  input  logic             qs_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
`ifdef SRT4_REM_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             dz
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int RW   = WIDTH + 6;
  localparam int QW   = WIDTH + 2;
  localparam int LZW  = $clog2(WIDTH) + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_FIX, S_DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     x_r, y_r, d_n, d_n_c, quo_c;
  logic [LZW-1:0]       lz, lz_c;
  logic signed [RW-1:0] r, dd, s, r_next;
  logic [QW-1:0]        q_r, qm_r, q_next, qm_next, qf;
  logic [CW-1:0]        cnt;
  logic [RW-1:0]        r_abs;
  logic [RW+1:0]        r_abs3, dd2;

  // Highest set bit wins, so the last match in the ascending loop gives the count.
  always_comb begin
    lz_c = '0;
    for (int i = 0; i < WIDTH; i++)
      if (y_r[i]) lz_c = LZW'(WIDTH - 1 - i);
  end

  assign d_n_c  = y_r << lz_c;
  assign s      = r <<< 2;
  assign qs_rem = s[WIDTH+4:WIDTH-1];
  assign qs_d   = d_n[WIDTH-1:WIDTH-4];

  // Recurrence step and on-the-fly conversion; unused encodings fall through as digit 0.
  always_comb begin
    r_next  = s;
    q_next  = {q_r[QW-3:0], 2'd0};
    qm_next = {qm_r[QW-3:0], 2'd3};
    case ({qs_neg, qs_q})
      3'b001: begin r_next = s - dd;         q_next = {q_r[QW-3:0], 2'd1};  qm_next = {q_r[QW-3:0], 2'd0};  end
      3'b010: begin r_next = s - (dd <<< 1); q_next = {q_r[QW-3:0], 2'd2};  qm_next = {q_r[QW-3:0], 2'd1};  end
      3'b101: begin r_next = s + dd;         q_next = {qm_r[QW-3:0], 2'd3}; qm_next = {qm_r[QW-3:0], 2'd2}; end
      3'b110: begin r_next = s + (dd <<< 1); q_next = {qm_r[QW-3:0], 2'd2}; qm_next = {qm_r[QW-3:0], 2'd1}; end
      default: ;
    endcase
  end

  assign qf    = r[RW-1] ? qm_r : q_r;
  assign quo_c = WIDTH'(qf >> (LZW'(WIDTH) - lz));

`ifdef SRT4_REM_EN
  logic [WIDTH-1:0] prod_lo;
  assign prod_lo = quo_c * y_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x_r       <= '0;
      y_r       <= '0;
      d_n       <= '0;
      lz        <= '0;
      r         <= '0;
      dd        <= '0;
      q_r       <= '0;
      qm_r      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      dz        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SRT4_REM_EN
      remainder <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          x_r      <= dividend;
          y_r      <= divisor;
          in_ready <= 1'b0;
          state    <= S_NORM;
        end
        S_NORM: begin
          lz   <= lz_c;
          d_n  <= d_n_c;
          dd   <= {4'b0000, d_n_c, 2'b00};
          r    <= {6'b000000, x_r};
          q_r  <= '0;
          qm_r <= '0;
          cnt  <= '0;
          if (y_r == '0) begin
            quotient  <= '1;
            dz        <= 1'b1;
            out_valid <= 1'b1;
`ifdef SRT4_REM_EN
            remainder <= x_r;
`endif
            state     <= S_DONE;
          end else begin
            state <= S_ITER;
          end
        end
        S_ITER: begin
          r    <= r_next;
          q_r  <= q_next;
          qm_r <= qm_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          quotient  <= quo_c;
          dz        <= 1'b0;
          out_valid <= 1'b1;
`ifdef SRT4_REM_EN
          remainder <= x_r - prod_lo;
`endif
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Convergence bound: 3|R| <= 2D whenever R holds a live partial remainder.
  assign r_abs  = r[RW-1] ? -r : r;
  assign r_abs3 = {2'b00, r_abs} + {1'b0, r_abs, 1'b0};
  assign dd2    = {1'b0, dd, 1'b0};

  assert property (@(posedge clk) disable iff (rst)
    (state == S_ITER || state == S_FIX) |-> (r_abs3 <= dd2));

endmodule

// File: tb/tb_srt4_iter_ctrl.sv
// tb/tb_srt4_iter_ctrl.sv - randomized self-checking bench for srt4_iter_ctrl
// Includes a behavioural radix-4 digit-selection table; define SRT4_REM_EN to check the remainder too.
module tb_srt4_iter_ctrl;

  localparam int W      = 8;
  localparam int N_ITER = W / 2 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, dz, qs_neg;
  logic [5:0]   qs_rem;
  logic [3:0]   qs_d;
  logic [1:0]   qs_q;
  logic [W-1:0] quotient;
`ifdef SRT4_REM_EN
  logic [W-1:0] remainder;
`endif
  int checks = 0;
  int failures = 0;
  int sel_dig;

  always #5 clk = ~clk;

  srt4_iter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .qs_rem(qs_rem), .qs_d(qs_d),
    .qs_q(qs_q), .qs_neg(qs_neg), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient),
`ifdef SRT4_REM_EN
    .remainder(remainder),
`endif
    .dz(dz)
  );

  // Thresholds in eighths: each digit k is chosen inside [(k-2/3)D, (k+2/3)D] for every D in the qs_d bucket.
  function automatic int select_digit(input logic [5:0] rem, input logic [3:0] d);
    int est, dv;
    est = int'($signed(rem));
    dv  = int'(d);
    if (est >= (2 * (dv + 1) + 2) / 3) return 2;
    if (est >= (dv + 6) / 6) return 1;
    if (est >= -(dv / 3)) return 0;
    if (est >= -((5 * dv) / 6)) return -1;
    return -2;
  endfunction

  always_comb begin
    sel_dig = select_digit(qs_rem, qs_d);
    qs_neg  = (sel_dig < 0);
    qs_q    = 2'((sel_dig < 0) ? -sel_dig : sel_dig);
  end

  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) ? '1 : W'(int'(x) / int'(y));
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) ? x : W'(int'(x) % int'(y));
  endfunction

  function automatic int ref_lat(input logic [W-1:0] y);
    return (y == 0) ? 2 : N_ITER + 3;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and wait (bounded) for out_valid; leaves the DUT in DONE.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] got_q, output logic got_dz,
                        output logic [W-1:0] got_rem, output int lat, output bit msb_ok);
    int n;
    dividend = x;
    divisor  = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    n = 1;
    msb_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (n >= 2 && n <= N_ITER + 1 && qs_d[3] !== 1'b1) msb_ok = 1'b0;
      tick();
      n++;
    end
    lat    = out_valid ? n : -1;
    got_q  = quotient;
    got_dz = dz;
`ifdef SRT4_REM_EN
    got_rem = remainder;
`else
    got_rem = '0;
`endif
  endtask

  task automatic release_result(output logic ov, output logic ir);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ov = out_valid;
    ir = in_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    checks += 6;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b expected=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    if (quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%0d expected=0", quotient); end
    if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b expected=0", dz); end
    if (qs_rem !== 6'd0) begin failures++; $display("FAIL reset_qs_rem got=%0d expected=0", qs_rem); end
    if (qs_d !== 4'd0) begin failures++; $display("FAIL reset_qs_d got=%0d expected=0", qs_d); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    logic [W-1:0] xs [6];
    logic [W-1:0] ys [6];
    logic [W-1:0] gq, gr;
    logic gdz, ov, ir;
    int lat;
    bit ok;
    xs = '{8'd100, 8'd255, 8'd255, 8'd0, 8'd200, 8'd1};
    ys = '{8'd7,   8'd1,   8'd255, 8'd5, 8'd0,   8'd128};
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], ys[i], gq, gdz, gr, lat, ok);
      checks += 6;
      if (gq !== ref_quot(xs[i], ys[i]))
        begin failures++; $display("FAIL dir_quotient x=%0d y=%0d got=%0d expected=%0d", xs[i], ys[i], gq, ref_quot(xs[i], ys[i])); end
      if (gdz !== (ys[i] == 0))
        begin failures++; $display("FAIL dir_dz x=%0d y=%0d got=%b expected=%b", xs[i], ys[i], gdz, ys[i] == 0); end
      if (lat != ref_lat(ys[i]))
        begin failures++; $display("FAIL dir_latency x=%0d y=%0d got=%0d expected=%0d", xs[i], ys[i], lat, ref_lat(ys[i])); end
      if (!ok) begin failures++; $display("FAIL dir_qs_d_msb x=%0d y=%0d got=0 expected=1", xs[i], ys[i]); end
`ifdef SRT4_REM_EN
      checks++;
      if (gr !== ref_rem(xs[i], ys[i]))
        begin failures++; $display("FAIL dir_remainder x=%0d y=%0d got=%0d expected=%0d", xs[i], ys[i], gr, ref_rem(xs[i], ys[i])); end
`endif
      release_result(ov, ir);
      if (ov !== 1'b0) begin failures++; $display("FAIL dir_release_out_valid got=%b expected=0", ov); end
      if (ir !== 1'b1) begin failures++; $display("FAIL dir_release_in_ready got=%b expected=1", ir); end
    end
  endtask

  task automatic test_hold_done;
    logic [W-1:0] gq, gr;
    logic gdz, ov, ir;
    int lat;
    bit ok;
    run_op(8'd50, 8'd6, gq, gdz, gr, lat, ok);
    checks += 2;
    if (gq !== ref_quot(8'd50, 8'd6)) begin failures++; $display("FAIL hold_first got=%0d expected=%0d", gq, ref_quot(8'd50, 8'd6)); end
    if (lat != N_ITER + 3) begin failures++; $display("FAIL hold_first_latency got=%0d expected=%0d", lat, N_ITER + 3); end
    dividend = 8'd77;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cycle=%0d got=%b expected=1", c, out_valid); end
      if (quotient !== ref_quot(8'd50, 8'd6)) begin failures++; $display("FAIL hold_quotient cycle=%0d got=%0d expected=%0d", c, quotient, ref_quot(8'd50, 8'd6)); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cycle=%0d got=%b expected=0", c, in_ready); end
    end
    in_valid = 1'b0;
    release_result(ov, ir);
    checks += 2;
    if (ov !== 1'b0) begin failures++; $display("FAIL hold_release_out_valid got=%b expected=0", ov); end
    if (ir !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready got=%b expected=1", ir); end
    run_op(8'd13, 8'd3, gq, gdz, gr, lat, ok);
    checks += 2;
    if (gq !== ref_quot(8'd13, 8'd3)) begin failures++; $display("FAIL hold_next_quotient got=%0d expected=%0d", gq, ref_quot(8'd13, 8'd3)); end
    if (lat != N_ITER + 3) begin failures++; $display("FAIL hold_next_latency got=%0d expected=%0d", lat, N_ITER + 3); end
    release_result(ov, ir);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] gq, gr;
    logic gdz, ov, ir;
    int lat;
    bit ok;
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b expected=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b expected=1", in_ready); end
    if (quotient !== '0) begin failures++; $display("FAIL midrst_quotient got=%0d expected=0", quotient); end
    #2 rst = 1'b0;
    tick();
    run_op(8'd9, 8'd2, gq, gdz, gr, lat, ok);
    checks += 2;
    if (gq !== ref_quot(8'd9, 8'd2)) begin failures++; $display("FAIL midrst_next_quotient got=%0d expected=%0d", gq, ref_quot(8'd9, 8'd2)); end
    if (lat != N_ITER + 3) begin failures++; $display("FAIL midrst_next_latency got=%0d expected=%0d", lat, N_ITER + 3); end
    release_result(ov, ir);
  endtask

  task automatic test_sweep;
    logic [W-1:0] x, y, gq, gr;
    logic gdz, ov, ir;
    int lat;
    bit ok;
    for (int i = 0; i < 255 + 300; i++) begin
      if (i < 255) begin
        y = W'(i + 1);
        x = (i % 2 == 0) ? 8'd255 : W'($urandom_range(0, 255));
      end else begin
        x = W'($urandom_range(0, 255));
        y = W'($urandom_range(1, 255));
      end
      run_op(x, y, gq, gdz, gr, lat, ok);
      checks += 4;
      if (gq !== ref_quot(x, y)) begin failures++; $display("FAIL sweep_quotient x=%0d y=%0d got=%0d expected=%0d", x, y, gq, ref_quot(x, y)); end
      if (gdz !== 1'b0) begin failures++; $display("FAIL sweep_dz x=%0d y=%0d got=%b expected=0", x, y, gdz); end
      if (lat != N_ITER + 3) begin failures++; $display("FAIL sweep_latency x=%0d y=%0d got=%0d expected=%0d", x, y, lat, N_ITER + 3); end
      if (!ok) begin failures++; $display("FAIL sweep_qs_d_msb x=%0d y=%0d got=0 expected=1", x, y); end
`ifdef SRT4_REM_EN
      checks++;
      if (gr !== ref_rem(x, y)) begin failures++; $display("FAIL sweep_remainder x=%0d y=%0d got=%0d expected=%0d", x, y, gr, ref_rem(x, y)); end
`endif
      repeat ($urandom_range(0, 2)) tick();
      release_result(ov, ir);
      checks++;
      if (ov !== 1'b0 || ir !== 1'b1) begin failures++; $display("FAIL sweep_release ov=%b ir=%b expected ov=0 ir=1", ov, ir); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_done();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srt4_iter_ctrl.md
Name: srt4_iter_ctrl

Overview:
- Sequential radix-4 SRT unsigned integer divider core.
- Feeds the radix-4 quotient-digit selection table directly downstream of it:
  - drives the 6-bit partial-remainder estimate and the 4-bit normalized-divisor estimate;
  - consumes the returned digit magnitude and sign.
- Owns normalization, the partial-remainder recurrence, on-the-fly quotient conversion, final correction and the valid/ready handshake.

Parameters:
- WIDTH, 8, dividend/divisor/quotient width. Must be even and >= 4.
- ITER, WIDTH/2+1, number of radix-4 iterations. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  high only in IDLE.
- dividend  in  WIDTH  unsigned x.
- divisor  in  WIDTH  unsigned y.
- qs_rem  out  6  two's-complement estimate of 4w, 3 fraction bits, to selection table.
- qs_d  out  4  top 4 bits of normalized divisor (1xxx).
- qs_q  in  2  digit magnitude from table: 00=0, 01=1, 10=2.
- qs_neg  in  1  digit sign from table.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  floor(x/y).
- dz  out  1  divide-by-zero flag, qualified by out_valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All datapath registers 0.
  - Outputs: in_ready=1, out_valid=0, quotient=0, dz=0, qs_rem=0, qs_d=0.
- States: IDLE, NORM, ITER, FIX, DONE.
- IDLE:
  - Accepts operands when in_valid & in_ready; latch x, y.
  - Next state NORM.
- NORM (1 cycle):
  - lz = leading-zero count of y.
  - d_n = y<<lz.
  - D = d_n<<2. D and R are WIDTH+6-bit signed, scale 2^(WIDTH+2).
  - R = zero-extended x.
  - Q = QM = 0; counter = 0.
  - If y==0: quotient = all ones, dz=1, go directly to DONE.
  - Else go to ITER.
- ITER (exactly ITER cycles):
  - S = R<<2, truncated to WIDTH+6 bits.
  - qs_rem = S[WIDTH+4:WIDTH-1]; qs_d = d_n[WIDTH-1:WIDTH-4]. Both combinational from registers.
  - Signed digit q = (qs_neg ? -1 : +1) * qs_q. Encoding 2'b11 is never returned; treat as 0.
  - Recurrence: R <= S - q*D.
  - On-the-fly conversion, Q and QM WIDTH+2 bits, shift in 2 bits per cycle:
    - Q <= (q>=0) ? {Q,q} : {QM,4+q}.
    - QM <= (q>0) ? {Q,q-1} : {QM,3+q}.
  - Counter increments. After ITER cycles go to FIX.
- FIX (1 cycle):
  - Qf = (R<0) ? QM : Q.
  - quotient <= Qf >> (WIDTH-lz), low WIDTH bits.
  - dz=0. Go to DONE.
- DONE:
  - out_valid=1; quotient and dz held stable.
  - On out_ready go to IDLE; out_valid drops next cycle.
  - in_ready stays 0 until IDLE, so there is no overlap between operations.
- Latency: handshake in cycle t gives out_valid=1 in cycle t+ITER+3 (t+8 for WIDTH=8). Divide-by-zero gives t+2.
- Invariant: |R| <= (2/3)D after every iteration. Violation is a table/datapath bug; it is checked by assertion in simulation.
- in_valid while busy is ignored; no buffering.
- Reset mid-operation aborts immediately and returns to IDLE; the result is discarded.
- x=0 completes normally, quotient=0.

Optional Feature:
- Macro SRT4_REM_EN.
- When defined:
  - Adds output port remainder (WIDTH).
  - In FIX, remainder <= x - quotient*y, using the WIDTH-bit product low bits. This is a registered multiply-subtract in the same cycle.
  - On divide-by-zero, remainder = x.
  - Held in DONE alongside quotient; reset value 0.
- When undefined: port and logic absent, latency unchanged.

Test Plan:
- x=100, y=7 -> quotient=14, dz=0, out_valid at t+8 (remainder=2 with SRT4_REM_EN).
- x=255, y=1 (lz=7) -> quotient=255; x=255, y=255 -> quotient=1; x=0, y=5 -> quotient=0.
- x=200, y=0 -> quotient=255, dz=1, out_valid at t+2 (remainder=200 with SRT4_REM_EN).
- Hold out_ready=0 for 5 cycles in DONE:
  - quotient and out_valid stable, in_ready=0, new in_valid ignored;
  - out_ready=1 -> IDLE next cycle, then next op 13/3 -> 4.
- Assert rst during ITER cycle 3 of 100/7:
  - out_valid=0, in_ready=1 immediately;
  - next op 9/2 -> 4 correct.
- Exhaustive WIDTH=8 sweep, all x and y != 0, against a reference model:
  - quotient exact;
  - |R| bound assertion never fires;
  - qs_d MSB always 1 during ITER.
